// File: rtl/nvme_queue_ctrl.sv
// Slot allocator, completion tracker and doorbell writer for one NVMe SQ/CQ pair.
// The SQ-tail and CQ-head doorbells share one AXI-Lite write master.
module nvme_queue_ctrl #(
  parameter int                       DEPTH         = 16,
  parameter int                       NL_ADDR_WIDTH = 32,
  parameter logic [NL_ADDR_WIDTH-1:0] SQ_DB_ADDR    = 32'h1008,
  parameter logic [NL_ADDR_WIDTH-1:0] CQ_DB_ADDR    = 32'h100C,
  localparam int                      SW            = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  output logic [SW-1:0]            alloc_slot,
  input  logic                     sub_done,
  input  logic                     cpl_valid,
  input  logic [SW-1:0]            cpl_cid,
  input  logic                     cpl_phase,
  output logic                     cpl_ready,
  output logic [NL_ADDR_WIDTH-1:0] nl_awaddr,
  output logic                     nl_awvalid,
  input  logic                     nl_awready,
  output logic [31:0]              nl_wdata,
  output logic [3:0]               nl_wstrb,
  output logic                     nl_wvalid,
  input  logic                     nl_wready,
  input  logic [1:0]               nl_bresp,
  input  logic                     nl_bvalid,
  output logic                     nl_bready,
  output logic [SW:0]              inflight,
  output logic                     err_cid,
  output logic                     err_sub,
  output logic                     err_db
);

  localparam logic [SW:0] MAX_INFL = (SW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {DB_IDLE, DB_ADDR, DB_RESP} db_state_e;

  logic [SW-1:0]    alloc_ptr_q, alloc_ptr_d;
  logic [SW-1:0]    commit_ptr_q, commit_ptr_d;
  logic [SW-1:0]    cq_head_q, cq_head_d;
  logic             exp_phase_q, exp_phase_d;
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [SW:0]      inflight_q, inflight_d;
  logic             err_cid_q, err_cid_d;
  logic             err_sub_q, err_sub_d;
  logic             cpl_ready_q;
  logic             alloc_fire, retire, cpl_take;

  db_state_e                db_state_q;
  logic                     db_cq_q, last_cq_q;
  logic [SW-1:0]            db_val_q, sq_rung_q, cq_rung_q;
  logic [NL_ADDR_WIDTH-1:0] awaddr_q;
  logic                     awvalid_q, wvalid_q, bready_q, err_db_q;
  logic                     sq_pend, cq_pend, pick_cq;

  assign alloc_ready = (inflight_q < MAX_INFL);
  assign alloc_slot  = alloc_ptr_q;
  assign inflight    = inflight_q;
  assign cpl_ready   = cpl_ready_q;
  assign err_cid     = err_cid_q;
  assign err_sub     = err_sub_q;
  assign err_db      = err_db_q;
  assign nl_awaddr   = awaddr_q;
  assign nl_awvalid  = awvalid_q;
  assign nl_wvalid   = wvalid_q;
  assign nl_wdata    = {{(32-SW){1'b0}}, db_val_q};
  assign nl_wstrb    = 4'hF;
  assign nl_bready   = bready_q;

  assign alloc_fire = alloc_valid && alloc_ready;
  assign cpl_take   = cpl_valid && cpl_ready_q && (cpl_phase == exp_phase_q);

  always_comb begin
    alloc_ptr_d  = alloc_ptr_q;
    commit_ptr_d = commit_ptr_q;
    cq_head_d    = cq_head_q;
    exp_phase_d  = exp_phase_q;
    busy_d       = busy_q;
    inflight_d   = inflight_q;
    err_cid_d    = 1'b0;
    err_sub_d    = 1'b0;
    retire       = 1'b0;

    if (sub_done) begin
      if (commit_ptr_q != alloc_ptr_q) commit_ptr_d = commit_ptr_q + SW'(1);
      else                             err_sub_d    = 1'b1;
    end

    // Stale-phase entries fall through untouched; accepted ones always advance the head
    if (cpl_take) begin
      cq_head_d = cq_head_q + SW'(1);
      if (&cq_head_q) exp_phase_d = ~exp_phase_q;
      if (busy_q[cpl_cid]) begin
        busy_d[cpl_cid] = 1'b0;
        retire          = 1'b1;
      end else begin
        err_cid_d = 1'b1;
      end
    end

    if (alloc_fire) begin
      busy_d[alloc_ptr_q] = 1'b1;
      alloc_ptr_d         = alloc_ptr_q + SW'(1);
    end

    case ({alloc_fire, retire})
      2'b10:   inflight_d = inflight_q + (SW+1)'(1);
      2'b01:   inflight_d = inflight_q - (SW+1)'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alloc_ptr_q  <= '0;
      commit_ptr_q <= '0;
      cq_head_q    <= '0;
      exp_phase_q  <= 1'b1;
      busy_q       <= '0;
      inflight_q   <= '0;
      err_cid_q    <= 1'b0;
      err_sub_q    <= 1'b0;
      cpl_ready_q  <= 1'b0;
    end else begin
      alloc_ptr_q  <= alloc_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      cq_head_q    <= cq_head_d;
      exp_phase_q  <= exp_phase_d;
      busy_q       <= busy_d;
      inflight_q   <= inflight_d;
      err_cid_q    <= err_cid_d;
      err_sub_q    <= err_sub_d;
      cpl_ready_q  <= 1'b1;
    end
  end

  // Round-robin: with both pending, serve whichever side did not go last
  assign sq_pend = (commit_ptr_q != sq_rung_q);
  assign cq_pend = (cq_head_q != cq_rung_q);
  assign pick_cq = cq_pend && (!sq_pend || !last_cq_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      db_state_q <= DB_IDLE;
      db_cq_q    <= 1'b0;
      last_cq_q  <= 1'b0;
      db_val_q   <= '0;
      sq_rung_q  <= '0;
      cq_rung_q  <= '0;
      awaddr_q   <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      err_db_q   <= 1'b0;
    end else begin
      err_db_q <= 1'b0;
      case (db_state_q)
        DB_IDLE: begin
          if (sq_pend || cq_pend) begin
            db_cq_q    <= pick_cq;
            db_val_q   <= pick_cq ? cq_head_q : commit_ptr_q;
            awaddr_q   <= pick_cq ? CQ_DB_ADDR : SQ_DB_ADDR;
            awvalid_q  <= 1'b1;
            wvalid_q   <= 1'b1;
            db_state_q <= DB_ADDR;
          end
        end
        DB_ADDR: begin
          if (nl_awready) awvalid_q <= 1'b0;
          if (nl_wready)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || nl_awready) && (!wvalid_q || nl_wready)) begin
            bready_q   <= 1'b1;
            db_state_q <= DB_RESP;
          end
        end
        DB_RESP: begin
          // Error responses are reported but the rung still advances: no retry
          if (nl_bvalid) begin
            bready_q  <= 1'b0;
            err_db_q  <= (nl_bresp != 2'b00);
            last_cq_q <= db_cq_q;
            if (db_cq_q) cq_rung_q <= db_val_q;
            else         sq_rung_q <= db_val_q;
            db_state_q <= DB_IDLE;
          end
        end
        default: db_state_q <= DB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvme_queue_ctrl.sv
// Directed bench for nvme_queue_ctrl: vector table for slot/completion bookkeeping,
// hand sequences for fill, phase wrap, doorbell arbitration, error response and reset.
module tb_nvme_queue_ctrl;
  localparam int SW = 4;
  localparam logic [31:0] SQ_ADDR = 32'h1008;
  localparam logic [31:0] CQ_ADDR = 32'h100C;

  logic          clk = 1'b0;
  logic          rstn;
  logic          alloc_valid, alloc_ready;
  logic [SW-1:0] alloc_slot;
  logic          sub_done, cpl_valid;
  logic [SW-1:0] cpl_cid;
  logic          cpl_phase, cpl_ready;
  logic [31:0]   nl_awaddr, nl_wdata;
  logic          nl_awvalid, nl_awready, nl_wvalid, nl_wready;
  logic [3:0]    nl_wstrb;
  logic [1:0]    nl_bresp;
  logic          nl_bvalid, nl_bready;
  logic [SW:0]   inflight;
  logic          err_cid, err_sub, err_db;

  always #5 clk = ~clk;

  nvme_queue_ctrl dut (
    .clk(clk), .rstn(rstn),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_slot(alloc_slot),
    .sub_done(sub_done), .cpl_valid(cpl_valid), .cpl_cid(cpl_cid),
    .cpl_phase(cpl_phase), .cpl_ready(cpl_ready),
    .nl_awaddr(nl_awaddr), .nl_awvalid(nl_awvalid), .nl_awready(nl_awready),
    .nl_wdata(nl_wdata), .nl_wstrb(nl_wstrb), .nl_wvalid(nl_wvalid), .nl_wready(nl_wready),
    .nl_bresp(nl_bresp), .nl_bvalid(nl_bvalid), .nl_bready(nl_bready),
    .inflight(inflight), .err_cid(err_cid), .err_sub(err_sub), .err_db(err_db)
  );

  // AXI-Lite slave: B returns combinationally once both AW and W were accepted
  logic        aw_seen, w_seen;
  logic [31:0] lat_addr, lat_data;
  logic [31:0] log_addr [0:63];
  logic [31:0] log_data [0:63];
  int          db_cnt;
  int          errdb_cnt = 0;

  assign nl_wready = 1'b1;
  assign nl_bvalid = aw_seen && w_seen;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_seen  <= 1'b0;
      w_seen   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      db_cnt   <= 0;
    end else begin
      if (nl_awvalid && nl_awready && !aw_seen) begin
        aw_seen  <= 1'b1;
        lat_addr <= nl_awaddr;
      end
      if (nl_wvalid && nl_wready && !w_seen) begin
        w_seen   <= 1'b1;
        lat_data <= nl_wdata;
      end
      if (nl_bvalid && nl_bready) begin
        aw_seen <= 1'b0;
        w_seen  <= 1'b0;
        if (db_cnt < 64) begin
          log_addr[db_cnt] <= lat_addr;
          log_data[db_cnt] <= lat_data;
          db_cnt           <= db_cnt + 1;
        end
      end
    end
  end

  always @(posedge clk) if (err_db) errdb_cnt <= errdb_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    alloc_valid = 1'b0;
    sub_done    = 1'b0;
    cpl_valid   = 1'b0;
    cpl_cid     = '0;
    cpl_phase   = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic last_write(input logic [31:0] addr, output logic [31:0] val);
    val = 32'hDEAD;
    for (int k = 0; k < db_cnt; k++)
      if (log_addr[k] == addr) val = log_data[k];
  endtask

  typedef struct {
    logic          av, sd, cv;
    logic [SW-1:0] cid;
    logic          ph;
    logic          rdy;
    logic [SW-1:0] slot;
    logic [SW:0]   infl;
    logic          ecid, esub;
  } vec_t;

  function automatic vec_t mk(int av, int sd, int cv, int cid, int ph,
                              int rdy, int slot, int infl, int ecid, int esub);
    vec_t v;
    v.av = 1'(av);  v.sd = 1'(sd);  v.cv = 1'(cv);  v.cid = SW'(cid);  v.ph = 1'(ph);
    v.rdy = 1'(rdy); v.slot = SW'(slot); v.infl = (SW+1)'(infl);
    v.ecid = 1'(ecid); v.esub = 1'(esub);
    return v;
  endfunction

  localparam int NV = 17;
  vec_t vec [NV];

  initial begin
    logic [31:0] v32;
    int c0, e0;

    //           av sd cv cid ph | rdy slot infl ecid esub
    vec[0]  = mk(1, 0, 0, 0, 0,   1, 1, 1, 0, 0);
    vec[1]  = mk(1, 0, 0, 0, 0,   1, 2, 2, 0, 0);
    vec[2]  = mk(1, 0, 0, 0, 0,   1, 3, 3, 0, 0);
    vec[3]  = mk(0, 1, 0, 0, 0,   1, 3, 3, 0, 0);
    vec[4]  = mk(0, 1, 0, 0, 0,   1, 3, 3, 0, 0);
    vec[5]  = mk(0, 1, 0, 0, 0,   1, 3, 3, 0, 0);
    vec[6]  = mk(0, 1, 0, 0, 0,   1, 3, 3, 0, 1);
    vec[7]  = mk(0, 0, 0, 0, 0,   1, 3, 3, 0, 0);
    vec[8]  = mk(0, 0, 1, 2, 1,   1, 3, 2, 0, 0);
    vec[9]  = mk(0, 0, 1, 0, 1,   1, 3, 1, 0, 0);
    vec[10] = mk(0, 0, 1, 1, 1,   1, 3, 0, 0, 0);
    vec[11] = mk(0, 0, 1, 5, 0,   1, 3, 0, 0, 0);
    vec[12] = mk(0, 0, 1, 5, 1,   1, 3, 0, 1, 0);
    vec[13] = mk(0, 0, 0, 0, 0,   1, 3, 0, 0, 0);
    vec[14] = mk(1, 0, 0, 0, 0,   1, 4, 1, 0, 0);
    vec[15] = mk(1, 0, 1, 3, 1,   1, 5, 1, 0, 0);
    vec[16] = mk(0, 0, 1, 4, 1,   1, 5, 0, 0, 0);

    clear_inputs();
    nl_awready = 1'b1;
    nl_bresp   = 2'b00;
    rstn       = 1'b0;
    tick();
    tick();
    chk("rst_alloc_slot", 32'(alloc_slot), 32'd0);
    chk("rst_cpl_ready",  32'(cpl_ready),  32'd0);
    chk("rst_inflight",   32'(inflight),   32'd0);
    chk("rst_valids",     32'({nl_awvalid, nl_wvalid, nl_bready}), 32'd0);
    chk("rst_errs",       32'({err_cid, err_sub, err_db}), 32'd0);
    rstn = 1'b1;
    tick();
    chk("post_rst_cpl_ready",   32'(cpl_ready),   32'd1);
    chk("post_rst_alloc_ready", 32'(alloc_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      alloc_valid = vec[i].av;
      sub_done    = vec[i].sd;
      cpl_valid   = vec[i].cv;
      cpl_cid     = vec[i].cid;
      cpl_phase   = vec[i].ph;
      tick();
      chk($sformatf("v%0d_ready", i),    32'(alloc_ready), 32'(vec[i].rdy));
      chk($sformatf("v%0d_slot", i),     32'(alloc_slot),  32'(vec[i].slot));
      chk($sformatf("v%0d_inflight", i), 32'(inflight),    32'(vec[i].infl));
      chk($sformatf("v%0d_err_cid", i),  32'(err_cid),     32'(vec[i].ecid));
      chk($sformatf("v%0d_err_sub", i),  32'(err_sub),     32'(vec[i].esub));
    end
    clear_inputs();
    repeat (12) tick();
    chk("db_count_nonzero", 32'(db_cnt > 1), 32'd1);
    last_write(SQ_ADDR, v32);
    chk("sq_db_last_value", v32, 32'd3);
    last_write(CQ_ADDR, v32);
    chk("cq_db_last_value", v32, 32'd6);
    chk("db_no_err", 32'(errdb_cnt), 32'd0);

    // Fill to DEPTH-1 and stall
    do_reset();
    alloc_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("fill%0d_slot", i),  32'(alloc_slot),  32'(i));
      chk($sformatf("fill%0d_ready", i), 32'(alloc_ready), 32'd1);
      tick();
    end
    chk("full_inflight", 32'(inflight),    32'd15);
    chk("full_ready",    32'(alloc_ready), 32'd0);
    tick();
    chk("stall_slot",     32'(alloc_slot), 32'd15);
    chk("stall_inflight", 32'(inflight),   32'd15);
    alloc_valid = 1'b0;

    // 16 accepted completions wrap cq_head and flip the expected phase
    cpl_valid = 1'b1; cpl_cid = 4'd0; cpl_phase = 1'b1;
    tick();
    cpl_valid = 1'b0;
    chk("wrap_first_retire", 32'(inflight), 32'd14);
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    chk("wrap_refill", 32'(inflight), 32'd15);
    for (int c = 1; c < 16; c++) begin
      cpl_valid = 1'b1; cpl_cid = SW'(c); cpl_phase = 1'b1;
      tick();
    end
    cpl_valid = 1'b0;
    chk("wrap_drained", 32'(inflight), 32'd0);
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    chk("wrap_alloc_slot0", 32'(inflight), 32'd1);
    cpl_valid = 1'b1; cpl_cid = 4'd0; cpl_phase = 1'b1;
    tick();
    chk("wrap_old_phase_ignored", 32'(inflight), 32'd1);
    chk("wrap_old_phase_no_err",  32'(err_cid),  32'd0);
    cpl_phase = 1'b0;
    tick();
    cpl_valid = 1'b0;
    chk("wrap_new_phase_taken", 32'(inflight), 32'd0);
    chk("wrap_new_phase_no_err", 32'(err_cid), 32'd0);

    // Arbitration from reset: CQ first, SQ value sampled at its own issue
    do_reset();
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    nl_awready = 1'b0;
    sub_done = 1'b1;
    cpl_valid = 1'b1; cpl_cid = 4'd5; cpl_phase = 1'b1;
    tick();
    clear_inputs();
    chk("arb_err_cid", 32'(err_cid), 32'd1);
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    chk("arb_first_awvalid", 32'(nl_awvalid), 32'd1);
    chk("arb_first_addr",    nl_awaddr,       CQ_ADDR);
    chk("arb_first_data",    nl_wdata,        32'd1);
    chk("arb_wstrb",         32'(nl_wstrb),   32'hF);
    chk("arb_err_cid_pulse", 32'(err_cid),    32'd0);
    sub_done = 1'b1;
    tick();
    sub_done = 1'b0;
    chk("arb_w_done_alone", 32'({nl_awvalid, nl_wvalid}), 32'b10);
    repeat (2) tick();
    chk("arb_aw_stalled", 32'(nl_awvalid), 32'd1);
    nl_awready = 1'b1;
    repeat (12) tick();
    chk("arb_db_count", 32'(db_cnt), 32'd2);
    chk("arb_db0_addr", log_addr[0], CQ_ADDR);
    chk("arb_db0_data", log_data[0], 32'd1);
    chk("arb_db1_addr", log_addr[1], SQ_ADDR);
    chk("arb_db1_data", log_data[1], 32'd2);

    // Error response still advances the rung pointer (no re-issue)
    nl_bresp = 2'b10;
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    c0 = db_cnt;
    e0 = errdb_cnt;
    sub_done = 1'b1;
    tick();
    sub_done = 1'b0;
    repeat (15) tick();
    chk("errdb_pulses",   32'(errdb_cnt - e0), 32'd1);
    chk("errdb_one_write", 32'(db_cnt - c0),   32'd1);
    last_write(SQ_ADDR, v32);
    chk("errdb_value", v32, 32'd3);
    nl_bresp = 2'b00;

    // Async reset while a doorbell is outstanding
    nl_awready = 1'b0;
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    sub_done = 1'b1;
    tick();
    sub_done = 1'b0;
    tick();
    chk("mid_awvalid", 32'(nl_awvalid), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_valids", 32'({nl_awvalid, nl_wvalid, nl_bready}), 32'd0);
    nl_awready = 1'b1;
    tick();
    rstn = 1'b1;
    repeat (10) tick();
    chk("mid_rst_no_reissue", 32'(db_cnt),   32'd0);
    chk("mid_rst_inflight",   32'(inflight), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
